button_debounce_sync: RTL and testbench

//  Upstream conditioning stage for the button-press event FSM. Takes a raw, asynchronous,

---
 rtl/button_debounce_sync.sv | 144 ++++++++++++++
 tb/tb_button_debounce_sync.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_sync.sv
// ---------------------------------------------------------------------------
// button_debounce_sync
//
// Conditions a raw, asynchronous, bouncing push-button line into a clean
// clk-synchronous level for the button-press event FSM. The raw line passes
// through a two-flop synchronizer. A four-state FSM then accepts a level
// change only after the synchronized sample has held the new value on
// STABLE_CYCLES+1 consecutive edges. A bounce during qualification sends the
// FSM back to the idle state for the current level.
//
// Parameters
//   STABLE_CYCLES  extra synchronized samples required to accept a change (>=1)
//   CNT_W          stability counter width; STABLE_CYCLES <= 2**CNT_W-1
//
// Ports
//   clk      in   single clock, all logic on posedge
//   rst_n    in   synchronous active-low reset
//   btn_raw  in   raw asynchronous button level, 1 = pressed
//   y        out  debounced synchronized level, 1 = pressed
//   rise     out  one-cycle strobe in the first cycle y is 1
//   fall     out  one-cycle strobe in the first cycle y is 0
//   busy     out  1 while a candidate change is being qualified
// ---------------------------------------------------------------------------
module button_debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic y,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sync1;
    logic             sync2;
    logic             btn_s;
    logic             y_next;
    logic             rise_next;
    logic             fall_next;
    logic             busy_next;

    assign btn_s = sync2;

    // Synchronizer, state register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE_LOW;
            cnt   <= '0;
            y     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            state <= state_next;
            cnt   <= cnt_next;
            y     <= y_next;
            rise  <= rise_next;
            fall  <= fall_next;
            busy  <= busy_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        y_next     = y;
        rise_next  = 1'b0;
        fall_next  = 1'b0;

        case (state)
            IDLE_LOW: begin
                if (btn_s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!btn_s) begin
                    // Glitch: drop the candidate silently.
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    y_next     = 1'b1;
                    rise_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!btn_s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (btn_s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    y_next     = 1'b0;
                    fall_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase

        // busy is registered with the state, so it follows the next state.
        busy_next = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
    end

endmodule

// File: tb/tb_button_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_button_debounce_sync
//
// Testbench for button_debounce_sync with STABLE_CYCLES=4. It applies a
// table of fixed vectors, then hand-written bounce, glitch and reset
// sequences, and then randomized stimulus. The randomized stimulus is
// compared against a run-length reference model: y flips once the
// synchronized input has differed from y on STABLE_CYCLES+1 consecutive
// edges.
// ---------------------------------------------------------------------------
module tb_button_debounce_sync;

    localparam int S = 4;

    logic clk;
    logic rst_n;
    logic btn_raw;
    logic y;
    logic rise;
    logic fall;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic m_s1, m_s2, m_y, m_rise, m_fall;
    int   m_run;

    button_debounce_sync #(
        .STABLE_CYCLES(S),
        .CNT_W        (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_raw),
        .y      (y),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       btn;
        logic [3:0] exp; // {y, rise, fall, busy}
    } vec_t;

    vec_t vecs[20];

    function automatic logic [3:0] dut_out();
        return {y, rise, fall, busy};
    endfunction

    function automatic logic [3:0] model_out();
        return {m_y, m_rise, m_fall, (m_run != 0)};
    endfunction

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: y/rise/fall/busy got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model update for one clock edge, using the inputs present at that edge.
    task automatic model_edge(input logic r, input logic b);
        logic bs;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!r) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_y   = 1'b0;
            m_run = 0;
        end else begin
            bs   = m_s2;
            m_s2 = m_s1;
            m_s1 = b;
            if (bs != m_y) begin
                m_run++;
                if (m_run == S + 1) begin
                    m_y    = bs;
                    m_rise = bs;
                    m_fall = !bs;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic b);
        rst_n   = r;
        btn_raw = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
    endtask

    task automatic step_chk(input string name, input logic r, input logic b);
        step(r, b);
        check4(name, dut_out(), model_out());
        check1({name, "_excl"}, rise & fall, 1'b0);
    endtask

    initial begin
        int hold;
        logic b;
        logic r;

        rst_n   = 1'b0;
        btn_raw = 1'b0;
        m_s1 = 0; m_s2 = 0; m_y = 0; m_rise = 0; m_fall = 0; m_run = 0;

        // reset, press held, release held
        vecs[0]  = '{1'b0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 1'b0, 4'b0000};
        vecs[2]  = '{1'b0, 1'b0, 4'b0000};
        vecs[3]  = '{1'b1, 1'b1, 4'b0000}; // press edge 0
        vecs[4]  = '{1'b1, 1'b1, 4'b0000}; // edge 1
        vecs[5]  = '{1'b1, 1'b1, 4'b0001}; // edge 2: busy
        vecs[6]  = '{1'b1, 1'b1, 4'b0001};
        vecs[7]  = '{1'b1, 1'b1, 4'b0001};
        vecs[8]  = '{1'b1, 1'b1, 4'b0001};
        vecs[9]  = '{1'b1, 1'b1, 4'b1100}; // edge 6: y, rise
        vecs[10] = '{1'b1, 1'b1, 4'b1000}; // edge 7: rise drops
        vecs[11] = '{1'b1, 1'b1, 4'b1000};
        vecs[12] = '{1'b1, 1'b0, 4'b1000}; // release edge 0
        vecs[13] = '{1'b1, 1'b0, 4'b1000};
        vecs[14] = '{1'b1, 1'b0, 4'b1001};
        vecs[15] = '{1'b1, 1'b0, 4'b1001};
        vecs[16] = '{1'b1, 1'b0, 4'b1001};
        vecs[17] = '{1'b1, 1'b0, 4'b1001};
        vecs[18] = '{1'b1, 1'b0, 4'b0010}; // edge 6: y low, fall
        vecs[19] = '{1'b1, 1'b0, 4'b0000};

        #2;
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst_n, vecs[i].btn);
            check4($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Bounce: 1 x3, 0 x1, then 1 held; y rises 6 edges after final 0->1 sample
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check1("bounce_norise", rise, 1'b0);
        end
        step(1'b1, 1'b0);
        check1("bounce_norise", rise, 1'b0);
        for (int j = 0; j <= 6; j++) begin
            step(1'b1, 1'b1);
            check1($sformatf("bounce_y_%0d", j), y, (j == 6));
            check1($sformatf("bounce_rise_%0d", j), rise, (j == 6));
        end
        for (int i = 0; i < 10; i++) step_chk("bounce_release", 1'b1, 1'b0);
        check1("bounce_release_y", y, 1'b0);

        // Single-cycle glitches every 3 cycles
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i % 3 == 0));
            check4($sformatf("glitch%0d", i), {y, rise, fall}, {1'b0, 3'b000});
        end
        for (int i = 0; i < 4; i++) step_chk("glitch_tail", 1'b1, 1'b0);

        // Reset at edge 4 of a qualification
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        check1("midrst_busy_before", busy, 1'b1);
        step(1'b0, 1'b1);
        check4("midrst_after", dut_out(), 4'b0000);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            check4($sformatf("midrst_quiet%0d", i), dut_out(), 4'b0000);
        end

        // Randomized runs against the reference model
        for (int k = 0; k < 400; k++) begin
            b    = 1'($urandom_range(0, 1));
            hold = (($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 12));
            for (int h = 0; h < hold; h++) begin
                r = ($urandom_range(0, 99) != 0);
                step_chk("rand", r, b);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
